// File: rtl/grill_pkg.sv
// Shared types for the grill timer: channel state encoding and prescaler sizing helper.
package grill_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 2'd0,
        ST_COOKING = 2'd1,
        ST_DONE    = 2'd2,
        ST_BURNT   = 2'd3
    } grill_state_e;

    // A divide-by-one prescaler still needs a one-bit register.
    function automatic int unsigned prescale_width(input int unsigned div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/grill_channel.sv
// One cooking channel: state machine, tick down-counter and registered done pulse.
module grill_channel
    import grill_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             tick,
    input  logic             start,
    input  logic             cancel,
    input  logic [CNT_W-1:0] cook_time,
    input  logic [CNT_W-1:0] burn_time,
    output grill_state_e     state,
    output logic             done_pulse
);

    grill_state_e     state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             enter_done;
    logic             done_d;

    // State, counter and pulse registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            cnt_q      <= '0;
            done_pulse <= 1'b0;
        end else begin
            state      <= state_d;
            cnt_q      <= cnt_d;
            done_pulse <= done_d;
        end
    end

    // Next state: cancel beats start, start beats tick.
    always_comb begin
        state_d    = state;
        cnt_d      = cnt_q;
        enter_done = 1'b0;
        if (cancel) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (start) begin
            if (cook_time == '0) begin
                state_d    = ST_DONE;
                cnt_d      = burn_time;
                enter_done = 1'b1;
            end else begin
                state_d = ST_COOKING;
                cnt_d   = cook_time;
            end
        end else if (tick) begin
            case (state)
                ST_COOKING: begin
                    if (cnt_q == CNT_W'(1)) begin
                        state_d    = ST_DONE;
                        cnt_d      = burn_time;
                        enter_done = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    // A zero burn count means the food is held warm forever.
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_BURNT;
                        cnt_d   = '0;
                    end else if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
        done_d = enter_done && !done_pulse;
    end

endmodule

// File: rtl/grill_timer.sv
// Multi-channel grill timer: shared tick prescaler feeding NUM_CH independent channels.
module grill_timer
    import grill_pkg::*;
#(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned TICK_DIV = 50000000,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  clock_en,
    input  logic [NUM_CH-1:0]     start,
    input  logic [NUM_CH-1:0]     cancel,
    input  logic [CNT_W-1:0]      cook_time,
    input  logic [CNT_W-1:0]      burn_time,
    output logic [2*NUM_CH-1:0]   ch_state,
    output logic [NUM_CH-1:0]     done_pulse,
    output logic                  any_burnt,
    output logic                  tick
);

    localparam int unsigned      PRE_W    = prescale_width(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0] pre_q;
    grill_state_e     ch_st [NUM_CH];

    // Prescaler advances only on enabled cycles.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pre_q <= '0;
        end else if (clock_en) begin
            pre_q <= (pre_q == PRE_LAST) ? '0 : pre_q + PRE_W'(1);
        end
    end

    assign tick = resetn & clock_en & (pre_q == PRE_LAST);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        grill_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk        (clk),
            .resetn     (resetn),
            .tick       (tick),
            .start      (start[i]),
            .cancel     (cancel[i]),
            .cook_time  (cook_time),
            .burn_time  (burn_time),
            .state      (ch_st[i]),
            .done_pulse (done_pulse[i])
        );
        assign ch_state[2*i +: 2] = ch_st[i];
    end

    always_comb begin
        any_burnt = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            any_burnt = any_burnt | (ch_st[i] == ST_BURNT);
        end
    end

endmodule

// File: tb/tb_grill_timer.sv
// Self-checking bench for grill_timer: vector table, directed corner sequences, random vs model.
module tb_grill_timer;

    localparam int unsigned NUM_CH   = 2;
    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned CNT_W    = 4;

    localparam int unsigned S_IDLE  = 0;
    localparam int unsigned S_COOK  = 1;
    localparam int unsigned S_DONE  = 2;
    localparam int unsigned S_BURNT = 3;

    logic                 clk = 1'b0;
    logic                 resetn;
    logic                 clock_en;
    logic [NUM_CH-1:0]    start;
    logic [NUM_CH-1:0]    cancel;
    logic [CNT_W-1:0]     cook_time;
    logic [CNT_W-1:0]     burn_time;
    logic [2*NUM_CH-1:0]  ch_state;
    logic [NUM_CH-1:0]    done_pulse;
    logic                 any_burnt;
    logic                 tick;

    always #5 clk = ~clk;

    grill_timer #(
        .NUM_CH   (NUM_CH),
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .clock_en   (clock_en),
        .start      (start),
        .cancel     (cancel),
        .cook_time  (cook_time),
        .burn_time  (burn_time),
        .ch_state   (ch_state),
        .done_pulse (done_pulse),
        .any_burnt  (any_burnt),
        .tick       (tick)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int n_ticks = 0;

    // Model: enabled-cycle phase, per-channel state and ticks remaining until next transition.
    int unsigned m_phase;
    int unsigned m_st  [NUM_CH];
    int unsigned m_rem [NUM_CH];
    bit          m_pulse [NUM_CH];

    typedef struct {
        logic [NUM_CH-1:0]   start;
        logic [NUM_CH-1:0]   cancel;
        logic [CNT_W-1:0]    cook;
        logic [CNT_W-1:0]    burn;
        logic [2*NUM_CH-1:0] exp_state;
        logic [NUM_CH-1:0]   exp_pulse;
        logic                exp_burnt;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2*NUM_CH-1:0] m_vec();
        logic [2*NUM_CH-1:0] v;
        for (int c = 0; c < NUM_CH; c++) v[2*c +: 2] = 2'(m_st[c]);
        return v;
    endfunction

    function automatic logic [NUM_CH-1:0] m_pvec();
        logic [NUM_CH-1:0] v;
        for (int c = 0; c < NUM_CH; c++) v[c] = m_pulse[c];
        return v;
    endfunction

    function automatic logic m_burnt();
        logic b;
        b = 1'b0;
        for (int c = 0; c < NUM_CH; c++) b = b | (m_st[c] == S_BURNT);
        return b;
    endfunction

    task automatic model_reset();
        m_phase = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            m_st[c] = S_IDLE;
            m_rem[c] = 0;
            m_pulse[c] = 1'b0;
        end
    endtask

    // Applies one clock edge of the timer rules to the model.
    task automatic model_edge();
        bit t;
        bit entered;
        t = clock_en && (m_phase == TICK_DIV - 1);
        if (clock_en) m_phase = (m_phase + 1) % TICK_DIV;
        for (int c = 0; c < NUM_CH; c++) begin
            entered = 1'b0;
            if (cancel[c]) begin
                m_st[c] = S_IDLE;
                m_rem[c] = 0;
            end else if (start[c]) begin
                if (cook_time == 0) begin
                    m_st[c] = S_DONE;
                    m_rem[c] = 32'(burn_time);
                    entered = 1'b1;
                end else begin
                    m_st[c] = S_COOK;
                    m_rem[c] = 32'(cook_time);
                end
            end else if (t && m_st[c] == S_COOK) begin
                m_rem[c]--;
                if (m_rem[c] == 0) begin
                    m_st[c] = S_DONE;
                    m_rem[c] = 32'(burn_time);
                    entered = 1'b1;
                end
            end else if (t && m_st[c] == S_DONE && m_rem[c] != 0) begin
                m_rem[c]--;
                if (m_rem[c] == 0) m_st[c] = S_BURNT;
            end
            m_pulse[c] = entered && !m_pulse[c];
        end
    endtask

    task automatic check_model();
        chk("ch_state", 32'(ch_state), 32'(m_vec()));
        chk("done_pulse", 32'(done_pulse), 32'(m_pvec()));
        chk("any_burnt", 32'(any_burnt), 32'(m_burnt()));
        chk("tick", 32'(tick), 32'(clock_en && (m_phase == TICK_DIV - 1)));
    endtask

    // Called just after a falling edge with inputs already set.
    task automatic step();
        #1;
        if (tick) n_ticks++;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_model();
    endtask

    task automatic clear_cmd();
        start  = '0;
        cancel = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        clear_cmd();
        #3;
        model_reset();
        @(negedge clk);
        check_model();
        resetn = 1'b1;
    endtask

    // Drops reset between clock edges and checks outputs clear before the next edge.
    task automatic async_reset();
        @(posedge clk);
        #2;
        resetn = 1'b0;
        clear_cmd();
        #1;
        chk("async_rst_state", 32'(ch_state), 32'd0);
        chk("async_rst_pulse", 32'(done_pulse), 32'd0);
        chk("async_rst_burnt", 32'(any_burnt), 32'd0);
        chk("async_rst_tick", 32'(tick), 32'd0);
        model_reset();
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic wait_state(input int ch, input logic [1:0] want, input int budget,
                              output int cycles);
        cycles = 0;
        while (cycles < budget) begin
            step();
            cycles++;
            if (ch_state[2*ch +: 2] == want) return;
        end
        chk("wait_timeout", 32'(cycles), 32'(budget + 1));
    endtask

    initial begin
        int cyc;
        int pulses;

        resetn    = 1'b0;
        clock_en  = 1'b0;
        start     = '0;
        cancel    = '0;
        cook_time = '0;
        burn_time = '0;

        vecs[0] = '{2'b01, 2'b00, 4'd0, 4'd0, 4'b0010, 2'b01, 1'b0};
        vecs[1] = '{2'b00, 2'b00, 4'd0, 4'd0, 4'b0010, 2'b00, 1'b0};
        vecs[2] = '{2'b10, 2'b00, 4'd5, 4'd0, 4'b0110, 2'b00, 1'b0};
        vecs[3] = '{2'b00, 2'b01, 4'd5, 4'd0, 4'b0100, 2'b00, 1'b0};
        vecs[4] = '{2'b10, 2'b10, 4'd0, 4'd0, 4'b0000, 2'b00, 1'b0};
        vecs[5] = '{2'b11, 2'b00, 4'd0, 4'd1, 4'b1010, 2'b11, 1'b0};
        vecs[6] = '{2'b00, 2'b00, 4'd0, 4'd1, 4'b1010, 2'b00, 1'b0};
        vecs[7] = '{2'b01, 2'b00, 4'd0, 4'd1, 4'b1010, 2'b01, 1'b0};
        vecs[8] = '{2'b10, 2'b00, 4'd3, 4'd1, 4'b0110, 2'b00, 1'b0};
        vecs[9] = '{2'b00, 2'b11, 4'd3, 4'd1, 4'b0000, 2'b00, 1'b0};

        // Command table with the prescaler frozen, so no ticks interfere.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            start     = vecs[i].start;
            cancel    = vecs[i].cancel;
            cook_time = vecs[i].cook;
            burn_time = vecs[i].burn;
            step();
            chk("vec_state", 32'(ch_state), 32'(vecs[i].exp_state));
            chk("vec_pulse", 32'(done_pulse), 32'(vecs[i].exp_pulse));
            chk("vec_burnt", 32'(any_burnt), 32'(vecs[i].exp_burnt));
        end

        // Cook 3 ticks, burn 2 ticks.
        do_reset();
        clock_en = 1'b1;
        n_ticks = 0;
        start = 2'b01; cook_time = 4'd3; burn_time = 4'd2;
        step();
        clear_cmd();
        wait_state(0, 2'(S_DONE), 100, cyc);
        chk("cook_ticks", 32'(n_ticks), 32'd3);
        chk("done_pulse_at_done", 32'(done_pulse[0]), 32'd1);
        wait_state(0, 2'(S_BURNT), 100, cyc);
        chk("burn_ticks", 32'(n_ticks), 32'd5);
        chk("burnt_flag", 32'(any_burnt), 32'd1);
        for (int i = 0; i < 12; i++) step();
        chk("burnt_holds", 32'(ch_state[1:0]), 32'(S_BURNT));

        // Reference latency, then the same cook with a 10-cycle freeze.
        do_reset();
        start = 2'b01; cook_time = 4'd3; burn_time = 4'd0;
        step();
        clear_cmd();
        wait_state(0, 2'(S_DONE), 100, cyc);
        chk("latency_plain", 32'(1 + cyc), 32'd12);
        do_reset();
        start = 2'b01;
        step();
        clear_cmd();
        step();
        step();
        clock_en = 1'b0;
        for (int i = 0; i < 10; i++) step();
        chk("frozen_cooking", 32'(ch_state[1:0]), 32'(S_COOK));
        clock_en = 1'b1;
        wait_state(0, 2'(S_DONE), 100, cyc);
        chk("latency_frozen", 32'(13 + cyc), 32'd22);

        // Cancel wins over a simultaneous start.
        do_reset();
        start = 2'b10; cook_time = 4'd5;
        step();
        clear_cmd();
        for (int i = 0; i < 5; i++) step();
        cancel = 2'b10; start = 2'b10; cook_time = 4'd2;
        step();
        chk("cancel_over_start", 32'(ch_state[3:2]), 32'(S_IDLE));
        chk("cancel_no_pulse", 32'(done_pulse[1]), 32'd0);
        clear_cmd();
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            pulses += int'(done_pulse[1]);
        end
        chk("cancel_no_later_pulse", 32'(pulses), 32'd0);

        // Zero cook time, zero burn time: held in DONE indefinitely.
        do_reset();
        start = 2'b01; cook_time = 4'd0; burn_time = 4'd0;
        step();
        chk("instant_done", 32'(ch_state[1:0]), 32'(S_DONE));
        chk("instant_pulse", 32'(done_pulse[0]), 32'd1);
        clear_cmd();
        pulses = 0;
        for (int i = 0; i < 84; i++) begin
            step();
            pulses += int'(done_pulse[0]);
        end
        chk("hold_done", 32'(ch_state[1:0]), 32'(S_DONE));
        chk("single_pulse", 32'(pulses), 32'd0);

        // Asynchronous reset while DONE.
        async_reset();
        step();
        chk("after_rst_idle", 32'(ch_state), 32'd0);

        // Reset mid-cook restarts the prescaler from zero.
        start = 2'b01; cook_time = 4'd9;
        step();
        clear_cmd();
        for (int i = 0; i < 6; i++) step();
        async_reset();
        start = 2'b01; cook_time = 4'd1;
        step();
        clear_cmd();
        wait_state(0, 2'(S_DONE), 50, cyc);
        chk("post_reset_first_tick", 32'(1 + cyc), 32'd4);

        // Both channels start together, then channel 1 restarts with a longer cook.
        do_reset();
        start = 2'b11; cook_time = 4'd2; burn_time = 4'd0;
        step();
        clear_cmd();
        wait_state(0, 2'(S_DONE), 100, cyc);
        chk("both_done", 32'(ch_state), 32'b1010);
        start = 2'b10; cook_time = 4'd3;
        step();
        clear_cmd();
        wait_state(1, 2'(S_DONE), 100, cyc);
        chk("ch1_later_done", 32'(ch_state), 32'b1010);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 800; i++) begin
            clock_en  = ($urandom_range(0, 9) != 0);
            for (int c = 0; c < NUM_CH; c++) begin
                start[c]  = ($urandom_range(0, 11) == 0);
                cancel[c] = ($urandom_range(0, 29) == 0);
            end
            cook_time = 4'($urandom_range(0, 6));
            burn_time = 4'($urandom_range(0, 4));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
